// File: rtl/conv_8_32_if.sv
// Byte-in / word-out bundle for the conv_8_32 deserializer.
// The upstream serializer (master) drives the byte side; conv_8_32 (slave) drives the word side.
interface conv_8_32_if;
    logic        valid_in;
    logic [7:0]  data_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        frame_err;
    logic [1:0]  byte_cnt;

    modport master (
        output valid_in,
        output data_in,
        input  data_out,
        input  valid_out,
        input  frame_err,
        input  byte_cnt
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output data_out,
        output valid_out,
        output frame_err,
        output byte_cnt
    );
endinterface

// File: rtl/conv_8_32.sv
// Byte-to-word deserializer on the fast (4f) clock: packs four consecutive valid bytes
// into a 32-bit word and stretches valid_out so a 1x-clock consumer can sample it.
module conv_8_32 #(
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned HOLD_CYCLES = 4     // legal range 1..4
) (
    input  logic        clk,
    input  logic        reset,
    conv_8_32_if.slave  bus
);

    // Handshake: valid-only, no backpressure. A byte is consumed on every rising edge
    // where valid_in=1; valid_out marks data_out as a fresh word and is never stalled.
    typedef enum logic [1:0] {
        COLLECT0 = 2'd0,
        COLLECT1 = 2'd1,
        COLLECT2 = 2'd2,
        COLLECT3 = 2'd3
    } state_t;

    localparam logic [1:0] HOLD_LOAD = 2'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [1:0]  hold_q, hold_d;
    logic        err_q, err_d;

    logic [1:0]  cnt;
    logic [1:0]  slot;
    logic [31:0] word;
    logic        complete;

    assign cnt = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        asm_d    = asm_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        hold_d   = hold_q;
        err_d    = 1'b0;
        complete = 1'b0;

        // Slot 3 is the top byte lane; MSB-first order fills lanes 3,2,1,0.
        slot = MSB_FIRST ? ~cnt : cnt;
        word = asm_q;
        word[{slot, 3'b000} +: 8] = bus.data_in;

        if (bus.valid_in) begin
            if (state_q == COLLECT3) begin
                complete = 1'b1;
                data_d   = word;
                asm_d    = '0;
                state_d  = COLLECT0;
            end else begin
                asm_d   = word;
                state_d = state_t'(cnt + 2'd1);
            end
        end else if (state_q != COLLECT0) begin
            // A gap inside a word drops the partial bytes; data_out is left untouched.
            state_d = COLLECT0;
            asm_d   = '0;
            err_d   = 1'b1;
        end

        // A completion reloads the stretch, so back-to-back words keep valid_out high.
        if (complete) begin
            valid_d = 1'b1;
            hold_d  = HOLD_LOAD;
        end else if (hold_q != 2'd0) begin
            valid_d = 1'b1;
            hold_d  = hold_q - 2'd1;
        end else begin
            valid_d = 1'b0;
            hold_d  = 2'd0;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.frame_err = err_q;
    assign bus.byte_cnt  = state_q;

endmodule

// File: tb/tb_conv_8_32.sv
// Directed bench for conv_8_32: one MSB-first and one LSB-first instance on a shared clock,
// with a small serializer model feeding the loopback scenario.
module tb_conv_8_32;

    logic clk;
    logic reset;

    conv_8_32_if if_m ();
    conv_8_32_if if_l ();

    conv_8_32 #(.MSB_FIRST(1'b1), .HOLD_CYCLES(4)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m.slave)
    );

    conv_8_32 #(.MSB_FIRST(1'b0), .HOLD_CYCLES(4)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l.slave)
    );

    int n_cmp;
    int n_err;
    logic [31:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a byte (or idle) to the MSB-first instance and advance one clock.
    task automatic step_m(input logic v, input logic [7:0] b);
        if_m.valid_in = v;
        if_m.data_in  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step_l(input logic v, input logic [7:0] b);
        if_l.valid_in = v;
        if_l.data_in  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_m.valid_in = 1'b0; if_m.data_in = 8'h00;
        if_l.valid_in = 1'b0; if_l.data_in = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (if_m.data_out !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected %h", if_m.data_out, 32'h0); end
        n_cmp++; if (if_m.valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", if_m.valid_out); end
        n_cmp++; if (if_m.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", if_m.frame_err); end
        n_cmp++; if (if_m.byte_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", if_m.byte_cnt); end
        n_cmp++; if (if_l.data_out !== 32'h0) begin n_err++; $display("FAIL reset_data_l: got %h expected %h", if_l.data_out, 32'h0); end
    endtask

    task automatic test_msb_word();
        logic [7:0] bytes [4];
        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) begin
            step_m(1'b1, bytes[i]);
            n_cmp++;
            if (if_m.byte_cnt !== 2'((i + 1) % 4)) begin
                n_err++; $display("FAIL msb_cnt[%0d]: got %0d expected %0d", i, if_m.byte_cnt, (i + 1) % 4);
            end
        end
        n_cmp++; if (if_m.data_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL msb_data: got %h expected %h", if_m.data_out, 32'hDEADBEEF); end
        n_cmp++; if (if_m.valid_out !== 1'b1) begin n_err++; $display("FAIL msb_valid0: got %b expected 1", if_m.valid_out); end
        for (int i = 1; i < 6; i++) begin
            step_m(1'b0, 8'h00);
            n_cmp++;
            if (if_m.valid_out !== (i < 4)) begin
                n_err++; $display("FAIL msb_hold[%0d]: got %b expected %b", i, if_m.valid_out, (i < 4));
            end
            n_cmp++;
            if (if_m.frame_err !== 1'b0) begin
                n_err++; $display("FAIL msb_err[%0d]: got %b expected 0", i, if_m.frame_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0 [4];
        logic [7:0] w1 [4];
        w0 = '{8'h01, 8'h02, 8'h03, 8'h04};
        w1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) step_m(1'b1, w0[i]);
        n_cmp++; if (if_m.data_out !== 32'h01020304) begin n_err++; $display("FAIL b2b_word0: got %h expected %h", if_m.data_out, 32'h01020304); end
        n_cmp++; if (if_m.valid_out !== 1'b1) begin n_err++; $display("FAIL b2b_valid0: got %b expected 1", if_m.valid_out); end
        for (int i = 0; i < 4; i++) begin
            step_m(1'b1, w1[i]);
            n_cmp++;
            if (if_m.valid_out !== 1'b1) begin
                n_err++; $display("FAIL b2b_valid_w1[%0d]: got %b expected 1", i, if_m.valid_out);
            end
            if (i < 3) begin
                n_cmp++;
                if (if_m.data_out !== 32'h01020304) begin
                    n_err++; $display("FAIL b2b_retain[%0d]: got %h expected %h", i, if_m.data_out, 32'h01020304);
                end
            end
        end
        n_cmp++; if (if_m.data_out !== 32'hA1B2C3D4) begin n_err++; $display("FAIL b2b_word1: got %h expected %h", if_m.data_out, 32'hA1B2C3D4); end
        for (int i = 1; i < 5; i++) begin
            step_m(1'b0, 8'h00);
            n_cmp++;
            if (if_m.valid_out !== (i < 4)) begin
                n_err++; $display("FAIL b2b_hold[%0d]: got %b expected %b", i, if_m.valid_out, (i < 4));
            end
        end
        n_cmp++; if (if_m.data_out !== 32'hA1B2C3D4) begin n_err++; $display("FAIL b2b_keep: got %h expected %h", if_m.data_out, 32'hA1B2C3D4); end
    endtask

    task automatic test_abort();
        logic [7:0] tail [4];
        tail = '{8'h33, 8'h44, 8'h55, 8'h66};
        step_m(1'b1, 8'h11);
        step_m(1'b1, 8'h22);
        n_cmp++; if (if_m.byte_cnt !== 2'd2) begin n_err++; $display("FAIL abort_cnt_pre: got %0d expected 2", if_m.byte_cnt); end
        step_m(1'b0, 8'h00);
        n_cmp++; if (if_m.frame_err !== 1'b1) begin n_err++; $display("FAIL abort_err: got %b expected 1", if_m.frame_err); end
        n_cmp++; if (if_m.byte_cnt !== 2'd0) begin n_err++; $display("FAIL abort_cnt: got %0d expected 0", if_m.byte_cnt); end
        n_cmp++; if (if_m.data_out !== 32'hA1B2C3D4) begin n_err++; $display("FAIL abort_data: got %h expected %h", if_m.data_out, 32'hA1B2C3D4); end
        n_cmp++; if (if_m.valid_out !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b expected 0", if_m.valid_out); end
        for (int i = 0; i < 4; i++) begin
            step_m(1'b1, tail[i]);
            n_cmp++;
            if (if_m.frame_err !== 1'b0) begin
                n_err++; $display("FAIL abort_err_after[%0d]: got %b expected 0", i, if_m.frame_err);
            end
        end
        n_cmp++; if (if_m.data_out !== 32'h33445566) begin n_err++; $display("FAIL abort_next: got %h expected %h", if_m.data_out, 32'h33445566); end
        n_cmp++; if (if_m.valid_out !== 1'b1) begin n_err++; $display("FAIL abort_next_valid: got %b expected 1", if_m.valid_out); end
        step_m(1'b0, 8'h00);
        n_cmp++; if (if_m.frame_err !== 1'b0) begin n_err++; $display("FAIL idle_no_err: got %b expected 0", if_m.frame_err); end
        for (int i = 0; i < 3; i++) step_m(1'b0, 8'h00);
        n_cmp++; if (if_m.valid_out !== 1'b0) begin n_err++; $display("FAIL abort_drain: got %b expected 0", if_m.valid_out); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w [4];
        w = '{8'h12, 8'h34, 8'h56, 8'h78};
        step_m(1'b1, 8'hAA);
        step_m(1'b1, 8'hBB);
        reset = 1'b1;
        step_m(1'b0, 8'h00);
        reset = 1'b0;
        n_cmp++; if (if_m.data_out !== 32'h0) begin n_err++; $display("FAIL midrst_data: got %h expected %h", if_m.data_out, 32'h0); end
        n_cmp++; if (if_m.valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", if_m.valid_out); end
        n_cmp++; if (if_m.frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b expected 0", if_m.frame_err); end
        n_cmp++; if (if_m.byte_cnt !== 2'd0) begin n_err++; $display("FAIL midrst_cnt: got %0d expected 0", if_m.byte_cnt); end
        for (int i = 0; i < 4; i++) step_m(1'b1, w[i]);
        n_cmp++; if (if_m.data_out !== 32'h12345678) begin n_err++; $display("FAIL midrst_next: got %h expected %h", if_m.data_out, 32'h12345678); end
        n_cmp++; if (if_m.frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_next_err: got %b expected 0", if_m.frame_err); end
        for (int i = 0; i < 4; i++) step_m(1'b0, 8'h00);
    endtask

    task automatic test_lsb_first();
        logic [7:0] bytes [4];
        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) step_l(1'b1, bytes[i]);
        n_cmp++; if (if_l.data_out !== 32'hEFBEADDE) begin n_err++; $display("FAIL lsb_data: got %h expected %h", if_l.data_out, 32'hEFBEADDE); end
        n_cmp++; if (if_l.valid_out !== 1'b1) begin n_err++; $display("FAIL lsb_valid: got %b expected 1", if_l.valid_out); end
        for (int i = 0; i < 4; i++) step_l(1'b0, 8'h00);
    endtask

    // Serializer model: each 32-bit word leaves as four bytes, most significant first, no gaps.
    task automatic test_loopback();
        logic [31:0] words [2];
        logic [31:0] w;
        logic [31:0] exp_w;
        words = '{32'hFFFF0000, 32'h0F0F0F0F};
        for (int k = 0; k < 2; k++) exp_q.push_back(words[k]);
        for (int k = 0; k < 2; k++) begin
            w = words[k];
            for (int j = 3; j >= 0; j--) begin
                step_m(1'b1, w[8*j +: 8]);
                n_cmp++;
                if (if_m.frame_err !== 1'b0) begin
                    n_err++; $display("FAIL loop_err[%0d.%0d]: got %b expected 0", k, j, if_m.frame_err);
                end
            end
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (if_m.data_out !== exp_w) begin
                n_err++; $display("FAIL loop_word[%0d]: got %h expected %h", k, if_m.data_out, exp_w);
            end
            n_cmp++;
            if (if_m.valid_out !== 1'b1) begin
                n_err++; $display("FAIL loop_valid[%0d]: got %b expected 1", k, if_m.valid_out);
            end
        end
        for (int i = 0; i < 4; i++) step_m(1'b0, 8'h00);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        test_reset();
        test_msb_word();
        test_back_to_back();
        test_abort();
        test_reset_mid_word();
        test_lsb_first();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
